pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of pipeline stages; legal range 2..16.
REQ-002 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-003 Derived STAGE_W = max(1, clog2(NUM_STAGES)).
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: launch request; honoured only while idle.
REQ-007 Port stall  input  1: freeze stage advance while active.
REQ-008 Port halt  input  1: request stop at the next instruction boundary.
REQ-009 Port step_mode  input  1: 1 = one instruction per start; 0 = continuous run.
REQ-010 Port active  output  1: sequencer running (registered).
REQ-011 Port stage_onehot  output  NUM_STAGES: one-hot current stage; bit0 = decode.
REQ-012 Port stage_index  output  STAGE_W: binary current stage.
REQ-013 Port last_stage  output  1: stage_index == NUM_STAGES-1 and active.
REQ-014 Port done  output  1: one-cycle pulse when the sequencer returns to idle.
REQ-015 Port instr_count  output  CNT_WIDTH: completed instructions.
REQ-016 Port cycle_count  output  CNT_WIDTH: cycles spent with active=1.

Function
REQ-017 advance = active AND NOT stall; the stage register increments by 1 on each advance cycle only.
REQ-018 Advance out of stage NUM_STAGES-1 SHALL wrap stage_index to 0 and increment instr_count by 1 in the same edge.
REQ-019 Idle (active=0) with start=1: active SHALL be 1 after the next edge; stage_index stays 0; halt_pending cleared.
REQ-020 start while active SHALL be ignored.
REQ-021 halt while active SHALL set an internal halt_pending flag; halt while idle SHALL be ignored, including when start is simultaneously high (start wins).
REQ-022 On the wrapping advance (REQ-018), if step_mode=1 OR halt=1 OR halt_pending=1, active SHALL be 0 after that edge, halt_pending cleared, and done=1 for exactly the following cycle; otherwise active stays 1.
REQ-023 step_mode SHALL be sampled only on the wrapping advance; changes mid-instruction take effect at that boundary.
REQ-024 stall on the last stage SHALL hold both stage and active; no wrap, no count, no done until stall drops.
REQ-025 stall and halt while idle SHALL have no effect.
REQ-026 cycle_count SHALL increment on every edge where active=1, stalled or not.
REQ-027 Both counters SHALL wrap modulo 2^CNT_WIDTH without saturation or flag.
REQ-028 stage_onehot SHALL have exactly one bit set at all times, bit[stage_index]; while idle, bit0.
REQ-029 stage_onehot and stage_index SHALL be combinationally forced to stage 0 while reset is high.
REQ-030 Latency: start at edge N -> active at N+1 -> first advance at N+2; unstalled instruction occupies exactly NUM_STAGES active cycles.

Reset
REQ-031 On a reset edge: active=0, stage_index=0, halt_pending=0, done=0, instr_count=0, cycle_count=0.
REQ-032 reset SHALL override all inputs on the same edge, including mid-instruction and during stall; no done pulse is generated.

Verification
REQ-033 NUM_STAGES=4, step_mode=1, start pulse -> active 4 cycles, stage_onehot 0001,0010,0100,1000, then active=0, done=1 for 1 cycle, instr_count=1, cycle_count=4.
REQ-034 NUM_STAGES=5, step_mode=0, start, halt pulse at stage 2 of instr 3 -> stages run to completion, active drops after instr 3 stage 4, instr_count=3, cycle_count=15, single done.
REQ-035 NUM_STAGES=4, step_mode=1, stall held 3 cycles at stage 3 -> no wrap or done during stall; done after release; cycle_count=7, instr_count=1.
REQ-036 Reset asserted at stage 2 of a continuous run -> next cycle all outputs zero, stage_onehot=0001, no done pulse.
REQ-037 start+halt same cycle while idle -> instruction launches, runs continuously (step_mode=0); start asserted while active -> no effect on stage sequence.
REQ-038 CNT_WIDTH=4, continuous run 17 instructions of NUM_STAGES=2 -> instr_count wraps to 1, cycle_count wraps to 2.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
//   Steps a single instruction through NUM_STAGES pipeline stages, either one
//   instruction per start (step mode) or continuously until halted. Keeps
//   free-running, wrapping counters of completed instructions and active cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | not running; stage held at 0; waits for start
//   RUN   | stepping through stages; leaves on a wrapping advance that is
//         | in step mode or has a halt request (live or pending)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   start         launch request, honoured only in IDLE
//   stall         freezes stage advance while RUN
//   halt          request stop at the next instruction boundary
//   step_mode     1 = one instruction per start, 0 = continuous
//   active        registered RUN indicator
//   stage_onehot  one-hot current stage (bit0 = decode)
//   stage_index   binary current stage
//   last_stage    active and on the final stage
//   done          one-cycle pulse after returning to IDLE
//   instr_count   completed instructions (wraps)
//   cycle_count   cycles spent active (wraps)
module pipeline_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 32,
  localparam int STAGE_W   = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  step_mode,
  output logic                  active,
  output logic [NUM_STAGES-1:0] stage_onehot,
  output logic [STAGE_W-1:0]    stage_index,
  output logic                  last_stage,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t               stateReg, stateNext;
  logic [STAGE_W-1:0]   stageReg, stageNext;
  logic                 haltPending, haltPendingNext;
  logic                 doneReg, doneNext;
  logic [CNT_WIDTH-1:0] instrCount, instrNext;
  logic [CNT_WIDTH-1:0] cycleCount, cycleNext;
  logic                 advance;
  logic                 wrapAdvance;

  assign active      = (stateReg == RUN);
  assign advance     = active && !stall;
  assign wrapAdvance = advance && (stageReg == LAST_STAGE);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      stageReg    <= '0;
      haltPending <= 1'b0;
      doneReg     <= 1'b0;
      instrCount  <= '0;
      cycleCount  <= '0;
    end else begin
      stateReg    <= stateNext;
      stageReg    <= stageNext;
      haltPending <= haltPendingNext;
      doneReg     <= doneNext;
      instrCount  <= instrNext;
      cycleCount  <= cycleNext;
    end
  end

  always_comb begin
    stateNext       = stateReg;
    stageNext       = stageReg;
    haltPendingNext = haltPending;
    doneNext        = 1'b0;
    instrNext       = instrCount;
    cycleNext       = active ? cycleCount + CNT_WIDTH'(1) : cycleCount;

    unique case (stateReg)
      IDLE: begin
        // halt and stall are meaningless here; start alone decides.
        if (start) begin
          stateNext       = RUN;
          stageNext       = '0;
          haltPendingNext = 1'b0;
        end
      end
      RUN: begin
        if (halt) haltPendingNext = 1'b1;
        if (wrapAdvance) begin
          stageNext = '0;
          instrNext = instrCount + CNT_WIDTH'(1);
          // step_mode only matters at the instruction boundary.
          if (step_mode || halt || haltPending) begin
            stateNext       = IDLE;
            haltPendingNext = 1'b0;
            doneNext        = 1'b1;
          end
        end else if (advance) begin
          stageNext = stageReg + STAGE_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Stage outputs read as decode while reset is held, before the edge lands.
  assign stage_index  = reset ? '0 : stageReg;
  assign stage_onehot = NUM_STAGES'(1) << stage_index;
  assign last_stage   = active && (stage_index == LAST_STAGE);
  assign done         = doneReg;
  assign instr_count  = instrCount;
  assign cycle_count  = cycleCount;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  logic clk = 1'b0;
  logic reset, start, stall, halt, stepMode;

  always #5 clk = ~clk;

  // Instance A: 4 stages, 32-bit counters
  logic        aActive, aLast, aDone;
  logic [3:0]  aOnehot;
  logic [1:0]  aIndex;
  logic [31:0] aInstr, aCycle;
  // Instance B: 5 stages
  logic        bActive, bLast, bDone;
  logic [4:0]  bOnehot;
  logic [2:0]  bIndex;
  logic [31:0] bInstr, bCycle;
  // Instance C: 2 stages, 4-bit counters
  logic        cActive, cLast, cDone;
  logic [1:0]  cOnehot;
  logic [0:0]  cIndex;
  logic [3:0]  cInstr, cCycle;

  pipeline_sequencer #(.NUM_STAGES(4), .CNT_WIDTH(32)) dutA (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .step_mode(stepMode), .active(aActive), .stage_onehot(aOnehot),
    .stage_index(aIndex), .last_stage(aLast), .done(aDone),
    .instr_count(aInstr), .cycle_count(aCycle));

  pipeline_sequencer #(.NUM_STAGES(5), .CNT_WIDTH(32)) dutB (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .step_mode(stepMode), .active(bActive), .stage_onehot(bOnehot),
    .stage_index(bIndex), .last_stage(bLast), .done(bDone),
    .instr_count(bInstr), .cycle_count(bCycle));

  pipeline_sequencer #(.NUM_STAGES(2), .CNT_WIDTH(4)) dutC (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .step_mode(stepMode), .active(cActive), .stage_onehot(cOnehot),
    .stage_index(cIndex), .last_stage(cLast), .done(cDone),
    .instr_count(cInstr), .cycle_count(cCycle));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rst, st, stl, hlt, step;
    int expActive, expIdx, expDone, expLast, expInstr, expCycle;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Apply inputs, take one rising edge, settle past it.
  task automatic tick(input int r, input int s, input int st, input int h, input int sm);
    reset    = r[0];
    start    = s[0];
    stall    = st[0];
    halt     = h[0];
    stepMode = sm[0];
    @(posedge clk);
    #1;
  endtask

  int doneSeen;

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; halt = 1'b0; stepMode = 1'b0;

    //           rst st stl hlt step | act idx done last instr cycle
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0};   // stall/halt idle: no effect
    vecs[2]  = '{0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0};   // step-mode launch
    vecs[3]  = '{0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 0, 2};
    vecs[5]  = '{0, 0, 0, 0, 1,   1, 3, 0, 1, 0, 3};
    vecs[6]  = '{0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 4};   // wrap -> idle, done
    vecs[7]  = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 4};
    vecs[8]  = '{0, 1, 0, 1, 0,   1, 0, 0, 0, 1, 4};   // start+halt idle: start wins
    vecs[9]  = '{0, 1, 0, 0, 0,   1, 1, 0, 0, 1, 5};   // start while active ignored
    vecs[10] = '{0, 0, 0, 0, 0,   1, 2, 0, 0, 1, 6};
    vecs[11] = '{0, 0, 0, 0, 0,   1, 3, 0, 1, 1, 7};
    vecs[12] = '{0, 0, 0, 0, 0,   1, 0, 0, 0, 2, 8};   // continuous wrap
    vecs[13] = '{0, 0, 1, 0, 0,   1, 0, 0, 0, 2, 9};   // stall holds stage
    vecs[14] = '{0, 0, 0, 0, 0,   1, 1, 0, 0, 2, 10};
    vecs[15] = '{0, 0, 0, 0, 1,   1, 2, 0, 0, 2, 11};  // step_mode mid-instr ignored
    vecs[16] = '{0, 0, 0, 0, 0,   1, 3, 0, 1, 2, 12};
    vecs[17] = '{0, 0, 0, 0, 1,   0, 0, 1, 0, 3, 13};  // step_mode at boundary stops
    vecs[18] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 3, 13};

    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      tick(vecs[i].rst, vecs[i].st, vecs[i].stl, vecs[i].hlt, vecs[i].step);
      chk($sformatf("row%0d active", i), aActive, vecs[i].expActive);
      chk($sformatf("row%0d index", i), aIndex, vecs[i].expIdx);
      chk($sformatf("row%0d onehot", i), aOnehot, 1 << vecs[i].expIdx);
      chk($sformatf("row%0d done", i), aDone, vecs[i].expDone);
      chk($sformatf("row%0d last", i), aLast, vecs[i].expLast);
      chk($sformatf("row%0d instr", i), aInstr, vecs[i].expInstr);
      chk($sformatf("row%0d cycle", i), aCycle, vecs[i].expCycle);
    end

    // Stall held three cycles on the last stage (4 stages, step mode)
    tick(1, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("lastStall reach3", aIndex, 3);
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 0, 1);
      chk($sformatf("lastStall%0d index", k), aIndex, 3);
      chk($sformatf("lastStall%0d active", k), aActive, 1);
      chk($sformatf("lastStall%0d done", k), aDone, 0);
      chk($sformatf("lastStall%0d instr", k), aInstr, 0);
    end
    tick(0, 0, 0, 0, 1);
    chk("lastStall release active", aActive, 0);
    chk("lastStall release done", aDone, 1);
    chk("lastStall instr", aInstr, 1);
    chk("lastStall cycle", aCycle, 7);

    // Reset at stage 2 of a continuous run
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("midReset pre index", aIndex, 2);
    reset = 1'b1;
    #1;
    chk("midReset comb index", aIndex, 0);
    chk("midReset comb onehot", aOnehot, 1);
    @(posedge clk);
    #1;
    chk("midReset active", aActive, 0);
    chk("midReset done", aDone, 0);
    chk("midReset instr", aInstr, 0);
    chk("midReset cycle", aCycle, 0);
    tick(0, 0, 0, 0, 0);
    chk("midReset after done", aDone, 0);
    chk("midReset after onehot", aOnehot, 1);

    // 5 stages, continuous, halt pulse at stage 2 of instruction 3
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    doneSeen = 0;
    for (int k = 1; k <= 15; k++) begin
      tick(0, 0, 0, (k == 13) ? 1 : 0, 0);
      if (bDone) doneSeen++;
      if (k == 12) chk("halt5 stage before halt", bIndex, 2);
      if (k < 15) chk($sformatf("halt5 active k%0d", k), bActive, 1);
    end
    chk("halt5 active end", bActive, 0);
    chk("halt5 instr", bInstr, 3);
    chk("halt5 cycle", bCycle, 15);
    tick(0, 0, 0, 0, 0);
    chk("halt5 done pulses", doneSeen + int'(bDone), 1);
    chk("halt5 idle", bActive, 0);

    // 2 stages, 4-bit counters: 17 instructions wrap both counters
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int k = 1; k <= 34; k++) begin
      tick(0, 0, 0, (k == 33) ? 1 : 0, 0);
      if (k == 32) chk("wrap instr at 16", cInstr, 0);
    end
    chk("wrap active", cActive, 0);
    chk("wrap done", cDone, 1);
    chk("wrap instr", cInstr, 1);
    chk("wrap cycle", cCycle, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
